// File: rtl/alu_result_checker.sv
// alu_result_checker
//   Self-checking monitor that sits on the consumer side of a small ALU.
//   Each vector presented with valid is captured into stage 1. One cycle
//   later, stage 2 recomputes the expected result and compares it. The
//   pass/fail counters saturate, and the first mismatch is latched for
//   display on the board.
//
//   Handshake: valid has no ready partner; the checker never stalls.
//   A vector is taken on any rising clk edge where all of these hold:
//     - the FSM is in RUN,
//     - valid=1,
//     - start=0,
//     - fewer than N_VECTORS vectors have been taken in the current run.
//   Vectors presented at any other time are dropped silently.
module alu_result_checker #(
    parameter int WIDTH     = 4,
    parameter int N_VECTORS = 20,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] ALU_out,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             fail_valid,
    output logic [CNT_W-1:0] fail_index,
    output logic [1:0]       fail_S,
    output logic [WIDTH-1:0] fail_A,
    output logic [WIDTH-1:0] fail_B,
    output logic [WIDTH-1:0] fail_got,
    output logic [WIDTH-1:0] fail_exp,
    output logic [1:0]       state_dbg
);

    // The vector index must reach N_VECTORS, even when CNT_W is narrower.
    localparam int IDX_W = $clog2(N_VECTORS + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VECTORS - 1);
    localparam logic [IDX_W-1:0] NUM_VEC  = IDX_W'(N_VECTORS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] vec_idx;
    logic             accept;

    logic             s1_valid;
    logic             s1_last;
    logic [IDX_W-1:0] s1_idx;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [1:0]       s1_s;
    logic [WIDTH-1:0] s1_out;

    logic [WIDTH-1:0] exp_val;
    logic             mismatch;

    assign accept    = (state == ST_RUN) && valid && !start && (vec_idx < NUM_VEC);
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the status flags derived from state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                // A start in RUN restarts the run, so the FSM stays in RUN.
                if (!start && s1_valid && s1_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign all_pass = done && (fail_count == '0);

    // Stage 1: capture each accepted vector and count vectors in this run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec_idx  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_idx   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_s     <= '0;
            s1_out   <= '0;
        end else if (start) begin
            // Restart: drop anything already in flight.
            vec_idx  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                vec_idx <= vec_idx + 1'b1;
                s1_last <= (vec_idx == LAST_IDX);
                s1_idx  <= vec_idx;
                s1_a    <= A;
                s1_b    <= B;
                s1_s    <= S;
                s1_out  <= ALU_out;
            end
        end
    end

    // Reference ALU. The add keeps only WIDTH bits, so the carry is discarded.
    always_comb begin
        exp_val = '0;
        case (s1_s)
            2'b00:   exp_val = s1_a ^ s1_b;
            2'b01:   exp_val = s1_a & s1_b;
            2'b10:   exp_val = s1_a | s1_b;
            default: exp_val = s1_a + s1_b;
        endcase
    end

    assign mismatch = (s1_out != exp_val);

    // Stage 2: saturating pass/fail counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (start) begin
            pass_count <= '0;
            fail_count <= '0;
        end else if (s1_valid) begin
            if (mismatch) begin
                if (fail_count != '1) begin
                    fail_count <= fail_count + 1'b1;
                end
            end else begin
                if (pass_count != '1) begin
                    pass_count <= pass_count + 1'b1;
                end
            end
        end
    end

    // Stage 2: latch the first mismatch of the run and hold it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_valid <= 1'b0;
            fail_index <= '0;
            fail_S     <= '0;
            fail_A     <= '0;
            fail_B     <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else if (start) begin
            fail_valid <= 1'b0;
            fail_index <= '0;
            fail_S     <= '0;
            fail_A     <= '0;
            fail_B     <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else if (s1_valid && mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_index <= CNT_W'(s1_idx);
            fail_S     <= s1_s;
            fail_A     <= s1_a;
            fail_B     <= s1_b;
            fail_got   <= s1_out;
            fail_exp   <= exp_val;
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker.
// The lab vector set and its hand-computed expected results live in tables.
// A second instance with CNT_W=4 shares the same stimulus; it is checked
// only in the saturation scenario.
module tb_alu_result_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic       valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] s;
    logic [3:0] alu_out;

    logic       busy;
    logic       done;
    logic       all_pass;
    logic       fail_valid;
    logic [7:0] pass_count;
    logic [7:0] fail_count;
    logic [7:0] fail_index;
    logic [1:0] fail_s;
    logic [3:0] fail_a;
    logic [3:0] fail_b;
    logic [3:0] fail_got;
    logic [3:0] fail_exp;
    logic [1:0] state_dbg;

    logic       busy2;
    logic       done2;
    logic       all_pass2;
    logic       fail_valid2;
    logic [3:0] pass_count2;
    logic [3:0] fail_count2;
    logic [3:0] fail_index2;
    logic [1:0] fail_s2;
    logic [3:0] fail_a2;
    logic [3:0] fail_b2;
    logic [3:0] fail_got2;
    logic [3:0] fail_exp2;
    logic [1:0] state_dbg2;

    int n_vec;
    int n_fail;

    logic [3:0] a_tab   [20];
    logic [3:0] b_tab   [20];
    logic [1:0] s_tab   [20];
    logic [3:0] exp_tab [20];
    logic [3:0] out_tab [20];

    alu_result_checker #(.WIDTH(4), .N_VECTORS(20), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .valid(valid),
        .A(a), .B(b), .S(s), .ALU_out(alu_out),
        .busy(busy), .done(done), .all_pass(all_pass),
        .pass_count(pass_count), .fail_count(fail_count),
        .fail_valid(fail_valid), .fail_index(fail_index),
        .fail_S(fail_s), .fail_A(fail_a), .fail_B(fail_b),
        .fail_got(fail_got), .fail_exp(fail_exp), .state_dbg(state_dbg)
    );

    alu_result_checker #(.WIDTH(4), .N_VECTORS(20), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .valid(valid),
        .A(a), .B(b), .S(s), .ALU_out(alu_out),
        .busy(busy2), .done(done2), .all_pass(all_pass2),
        .pass_count(pass_count2), .fail_count(fail_count2),
        .fail_valid(fail_valid2), .fail_index(fail_index2),
        .fail_S(fail_s2), .fail_A(fail_a2), .fail_B(fail_b2),
        .fail_got(fail_got2), .fail_exp(fail_exp2), .state_dbg(state_dbg2)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the lab set: the pairs below, each applied with S = 00..11.
    // exp_tab holds the hand-computed results.
    task automatic init_tables();
        logic [3:0] pa [5];
        logic [3:0] pb [5];
        pa = '{4'b1001, 4'b0000, 4'b1111, 4'b1010, 4'b0010};
        pb = '{4'b1001, 4'b1111, 4'b1111, 4'b0101, 4'b0011};
        exp_tab = '{4'b0000, 4'b1001, 4'b1001, 4'b0010,
                    4'b1111, 4'b0000, 4'b1111, 4'b1111,
                    4'b0000, 4'b1111, 4'b1111, 4'b1110,
                    4'b1111, 4'b0000, 4'b1111, 4'b1111,
                    4'b0001, 4'b0010, 4'b0011, 4'b0101};
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 4; k++) begin
                a_tab[p*4+k] = pa[p];
                b_tab[p*4+k] = pb[p];
                s_tab[p*4+k] = 2'(k);
            end
        end
        out_tab = exp_tab;
    endtask

    task automatic drive_vec(input int i);
        valid   = 1'b1;
        a       = a_tab[i];
        b       = b_tab[i];
        s       = s_tab[i];
        alu_out = out_tab[i];
        tick();
    endtask

    task automatic drive_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive_vec(i);
        end
    endtask

    task automatic idle_cycle();
        valid = 1'b0;
        tick();
    endtask

    task automatic start_run();
        start = 1'b1;
        valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        a = '0;
        b = '0;
        s = '0;
        alu_out = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
        n_vec++; if (all_pass !== 1'b0) begin n_fail++; $display("FAIL reset_all_pass: got %b exp 0", all_pass); end
        n_vec++; if (fail_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fail_valid: got %b exp 0", fail_valid); end
        n_vec++; if ({pass_count, fail_count} !== 16'h0) begin n_fail++; $display("FAIL reset_counts: got %h exp 0000", {pass_count, fail_count}); end
        // valid while IDLE must be ignored.
        drive_range(0, 3);
        idle_cycle();
        idle_cycle();
        n_vec++; if (pass_count !== 8'd0) begin n_fail++; $display("FAIL idle_valid_ignored: got %0d exp 0", pass_count); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b exp 0", busy); end
    endtask

    task automatic test_lab_pass();
        out_tab = exp_tab;
        start_run();
        n_vec++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b exp 1", busy); end
        drive_vec(0);
        n_vec++; if (pass_count !== 8'd0) begin n_fail++; $display("FAIL latency_1clk: got %0d exp 0", pass_count); end
        drive_vec(1);
        n_vec++; if (pass_count !== 8'd1) begin n_fail++; $display("FAIL latency_2clk: got %0d exp 1", pass_count); end
        drive_range(2, 19);
        valid = 1'b0;
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b exp 0", done); end
        tick();
        n_vec++; if (done !== 1'b1) begin n_fail++; $display("FAIL lab_done: got %b exp 1", done); end
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lab_busy: got %b exp 0", busy); end
        n_vec++; if (pass_count !== 8'd20) begin n_fail++; $display("FAIL lab_pass_count: got %0d exp 20", pass_count); end
        n_vec++; if (fail_count !== 8'd0) begin n_fail++; $display("FAIL lab_fail_count: got %0d exp 0", fail_count); end
        n_vec++; if (all_pass !== 1'b1) begin n_fail++; $display("FAIL lab_all_pass: got %b exp 1", all_pass); end
        n_vec++; if (fail_valid !== 1'b0) begin n_fail++; $display("FAIL lab_fail_valid: got %b exp 0", fail_valid); end
        tick();
        n_vec++; if (done !== 1'b1 || pass_count !== 8'd20) begin n_fail++; $display("FAIL done_hold: got done=%b pass=%0d exp done=1 pass=20", done, pass_count); end
    endtask

    task automatic test_lab_fail();
        out_tab = exp_tab;
        out_tab[3] = 4'b0011;
        out_tab[7] = 4'b0000;
        start_run();
        drive_range(0, 19);
        idle_cycle();
        n_vec++; if (fail_count !== 8'd2) begin n_fail++; $display("FAIL two_fail_count: got %0d exp 2", fail_count); end
        n_vec++; if (pass_count !== 8'd18) begin n_fail++; $display("FAIL two_pass_count: got %0d exp 18", pass_count); end
        n_vec++; if (fail_index !== 8'd3) begin n_fail++; $display("FAIL two_fail_index: got %0d exp 3", fail_index); end
        n_vec++; if (fail_exp !== 4'b0010) begin n_fail++; $display("FAIL two_fail_exp: got %b exp 0010", fail_exp); end
        n_vec++; if (fail_got !== 4'b0011) begin n_fail++; $display("FAIL two_fail_got: got %b exp 0011", fail_got); end
        n_vec++; if (fail_s !== 2'b11) begin n_fail++; $display("FAIL two_fail_s: got %b exp 11", fail_s); end
        n_vec++; if ({fail_a, fail_b} !== 8'b1001_1001) begin n_fail++; $display("FAIL two_fail_ab: got %b exp 10011001", {fail_a, fail_b}); end
        n_vec++; if (fail_valid !== 1'b1) begin n_fail++; $display("FAIL two_fail_valid: got %b exp 1", fail_valid); end
        n_vec++; if (all_pass !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL two_done_all_pass: got %b%b exp 10", done, all_pass); end
    endtask

    task automatic test_overflow();
        out_tab = exp_tab;
        out_tab[11] = 4'b1111;
        start_run();
        drive_range(0, 19);
        idle_cycle();
        n_vec++; if (fail_count !== 8'd1) begin n_fail++; $display("FAIL ovf_fail_count: got %0d exp 1", fail_count); end
        n_vec++; if (fail_index !== 8'd11) begin n_fail++; $display("FAIL ovf_fail_index: got %0d exp 11", fail_index); end
        n_vec++; if (fail_exp !== 4'b1110) begin n_fail++; $display("FAIL ovf_fail_exp: got %b exp 1110", fail_exp); end
        n_vec++; if (fail_got !== 4'b1111) begin n_fail++; $display("FAIL ovf_fail_got: got %b exp 1111", fail_got); end
    endtask

    task automatic test_async_reset();
        out_tab = exp_tab;
        start_run();
        drive_range(0, 9);
        n_vec++; if (pass_count !== 8'd9) begin n_fail++; $display("FAIL pre_reset_pass: got %0d exp 9", pass_count); end
        valid = 1'b1;
        a = a_tab[10];
        b = b_tab[10];
        s = s_tab[10];
        alu_out = out_tab[10];
        #2 reset = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b exp 0", busy); end
        n_vec++; if (pass_count !== 8'd0) begin n_fail++; $display("FAIL async_pass: got %0d exp 0", pass_count); end
        n_vec++; if ({done, all_pass, fail_valid} !== 3'b000) begin n_fail++; $display("FAIL async_flags: got %b exp 000", {done, all_pass, fail_valid}); end
        #2 reset = 1'b0;
        tick();
        drive_range(11, 13);
        idle_cycle();
        n_vec++; if (pass_count !== 8'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_ignore: got pass=%0d busy=%b exp pass=0 busy=0", pass_count, busy); end
    endtask

    task automatic test_restart();
        out_tab = exp_tab;
        out_tab[5] = 4'b0110;
        start_run();
        drive_range(0, 11);
        n_vec++; if (fail_count !== 8'd1 || pass_count !== 8'd10) begin n_fail++; $display("FAIL pre_restart: got pass=%0d fail=%0d exp pass=10 fail=1", pass_count, fail_count); end
        // start together with a bad vector: the vector must not be sampled.
        out_tab[12] = 4'b1010;
        start = 1'b1;
        drive_vec(12);
        start = 1'b0;
        n_vec++; if ({pass_count, fail_count} !== 16'h0) begin n_fail++; $display("FAIL restart_clear: got %h exp 0000", {pass_count, fail_count}); end
        n_vec++; if (fail_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_flags: got fv=%b busy=%b exp fv=0 busy=1", fail_valid, busy); end
        out_tab = exp_tab;
        drive_range(0, 19);
        valid = 1'b0;
        n_vec++; if (done !== 1'b0 || pass_count !== 8'd19) begin n_fail++; $display("FAIL restart_last_edge: got done=%b pass=%0d exp done=0 pass=19", done, pass_count); end
        tick();
        n_vec++; if (done !== 1'b1 || pass_count !== 8'd20) begin n_fail++; $display("FAIL restart_done: got done=%b pass=%0d exp done=1 pass=20", done, pass_count); end
    endtask

    task automatic test_back_to_back();
        // From DONE: start with valid in the same cycle, 20 valids back to back,
        // then 2 extra bad valids that must be ignored.
        out_tab = exp_tab;
        out_tab[0] = 4'b1111;
        start = 1'b1;
        drive_vec(0);
        start = 1'b0;
        out_tab = exp_tab;
        drive_range(0, 19);
        out_tab[0] = 4'b0111;
        out_tab[1] = 4'b0111;
        drive_range(0, 1);
        idle_cycle();
        n_vec++; if (pass_count !== 8'd20) begin n_fail++; $display("FAIL b2b_pass: got %0d exp 20", pass_count); end
        n_vec++; if (fail_count !== 8'd0) begin n_fail++; $display("FAIL b2b_fail: got %0d exp 0", fail_count); end
        n_vec++; if (all_pass !== 1'b1) begin n_fail++; $display("FAIL b2b_all_pass: got %b exp 1", all_pass); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            out_tab[i] = exp_tab[i] ^ 4'b0001;
        end
        start_run();
        drive_range(0, 19);
        idle_cycle();
        n_vec++; if (fail_count2 !== 4'd15) begin n_fail++; $display("FAIL sat_fail_count: got %0d exp 15", fail_count2); end
        n_vec++; if (done2 !== 1'b1 || all_pass2 !== 1'b0) begin n_fail++; $display("FAIL sat_done: got done=%b ap=%b exp done=1 ap=0", done2, all_pass2); end
        n_vec++; if (fail_index2 !== 4'd0) begin n_fail++; $display("FAIL sat_fail_index: got %0d exp 0", fail_index2); end
        n_vec++; if (fail_count !== 8'd20 || pass_count !== 8'd0) begin n_fail++; $display("FAIL wide_counts: got pass=%0d fail=%0d exp pass=0 fail=20", pass_count, fail_count); end
        n_vec++; if ({fail_exp, fail_got} !== 8'b0000_0001) begin n_fail++; $display("FAIL sat_capture: got %b exp 00000001", {fail_exp, fail_got}); end
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        init_tables();
        test_reset();
        test_lab_pass();
        test_lab_fail();
        test_overflow();
        test_async_reset();
        test_restart();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Synthesizable self-checking monitor on the consumer side of the 4-bit ALU interface (A, B, S, ALU_out).
- Samples each presented operand/select/result vector on a valid strobe and recomputes the expected ALU result.
- Counts passes and failures and captures the first mismatch for display on board LEDs/7-seg.
- Sits beside the ALU on the lab board so a vector run can be self-checked in hardware, not only in simulation.

Parameters:
- WIDTH, 4: operand/result width.
- N_VECTORS, 20: vectors per run; run ends after this many valid samples.
- CNT_W, 8: pass/fail counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run.
- valid  input  1  A/B/S/ALU_out are stable and form one vector this cycle.
- A  input  WIDTH  operand A as applied to the ALU.
- B  input  WIDTH  operand B as applied to the ALU.
- S  input  2  ALU select: 00 XOR, 01 AND, 10 OR, 11 ADD.
- ALU_out  input  WIDTH  result produced by the ALU.
- busy  output  1  run in progress.
- done  output  1  run complete; held until next start or reset.
- all_pass  output  1  done and fail_count == 0.
- pass_count  output  CNT_W  vectors matched.
- fail_count  output  CNT_W  vectors mismatched.
- fail_valid  output  1  first-failure capture registers hold data.
- fail_index  output  CNT_W  vector number (0-based) of first failure.
- fail_S  output  2  select of first failure.
- fail_A  output  WIDTH  operand A of first failure.
- fail_B  output  WIDTH  operand B of first failure.
- fail_got  output  WIDTH  ALU_out of first failure.
- fail_exp  output  WIDTH  expected value of first failure.

Behaviour:
- Reset (async, any time including mid-run):
  - FSM goes to IDLE.
  - Outputs busy, done, all_pass, fail_valid clear to 0.
  - All counters and capture registers clear to 0.
- Expected value:
  - S=00 → A^B; S=01 → A&B; S=10 → A|B.
  - S=11 → (A+B) mod 2^WIDTH; carry is discarded (1001+1001 → 0010, 1111+1111 → 1110).
- FSM state IDLE:
  - valid is ignored.
  - start → RUN: clears counters, fail_valid and vec_idx; sets busy=1.
- FSM state RUN, stage 1:
  - On each cycle with valid=1, register A, B, S, ALU_out and vec_idx into stage 1; increment vec_idx.
- FSM state RUN, stage 2 (one cycle later):
  - Compare the registered result against the expected value.
  - Match: increment pass_count. Mismatch: increment fail_count.
  - On a mismatch with fail_valid=0, load all fail_* registers and set fail_valid=1.
  - Later mismatches leave the capture untouched.
- Latency: a counter reflects a sampled vector 2 clocks after the valid edge.
- Counters saturate at 2^CNT_W−1; no wrap.
- End of run:
  - When the N_VECTORS-th valid is sampled, further valid is ignored.
  - After its stage-2 compare completes, FSM → DONE: busy=0, done=1, all_pass=(fail_count==0).
- FSM state DONE:
  - Results hold.
  - start → RUN (fresh run, same clear as from IDLE).
- start asserted during RUN: restarts the run immediately and clears counters. A vector in stage 2 that cycle is discarded.
- start and valid in the same cycle from IDLE/DONE: the valid is not sampled; the first vector is the next valid.
- Back-to-back valid every cycle is supported with no stalls.

Test Plan:
- Reset, start, N_VECTORS=20, correct ALU driven with the lab set (A/B = 1001/1001, 0000/1111, 1111/1111, 1010/0101, 0010/0011 × S=00..11) → done=1, pass_count=20, fail_count=0, all_pass=1, fail_valid=0.
- Same run with ALU_out forced to 0011 on vector 3 (A=B=1001, S=11, expected 0010) and to 0000 on vector 7 → fail_count=2, pass_count=18, fail_index=3, fail_exp=0010, fail_got=0011, fail_S=11, all_pass=0.
- Add overflow: A=B=1111, S=11, ALU_out=1110 → pass. ALU_out=11110 truncated/1111 supplied → fail, fail_exp=1110.
- Assert reset for one cycle in the middle of vector 10 → all outputs 0 immediately (asynchronous); valid ignored until the next start.
- start pulsed at vector 12 of a run → counters restart at 0; run ends after 20 further valids, with done asserting 2 cycles after the last one.
- CNT_W=4, N_VECTORS=20, all mismatching → fail_count saturates at 15, done=1, fail_index=0.
